program_counter: RTL and testbench
==================================

Name: program_counter

Overview:
Program counter stage directly downstream of the CPU control FSM. Consumes the FSM's one-cycle `PCe` pulse, issued once per 3-cycle instruction slot, and advances the PC. Captures branch, jump, call and return requests that arrive at any point in the slot and applies them on the next `PCe` pulse. Drives the instruction-memory address and a sequential return address.

Parameters:
- ADDR_WIDTH, 16, width of PC and all address ports
- DISP_WIDTH, 8, width of the signed branch displacement
- RESET_VECTOR, 16'h0000, PC value after reset
- RAS_DEPTH, 4, return-stack entries (used only with RAS_EN)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- PCe  input  1  PC update strobe from the control FSM
- br_req  input  1  relative branch request (single-cycle pulse)
- br_disp  input  DISP_WIDTH  signed displacement; sampled with br_req
- jmp_req  input  1  absolute jump request (single-cycle pulse)
- jmp_addr  input  ADDR_WIDTH  jump target; sampled with jmp_req
- call  input  1  qualifies jmp_req as a call (save return address)
- ret  input  1  return request (single-cycle pulse)
- pc  output  ADDR_WIDTH  current PC, registered
- pc_plus1  output  ADDR_WIDTH  pc+1, combinational from pc
- pend  output  1  a redirect is latched and waiting for PCe
- ras_err  output  1  sticky stack over/underflow flag (RAS_EN only; tied 0 otherwise)

Behaviour:
- Reset, asynchronous: `pc=RESET_VECTOR`, `pend=0`, pending target=0, link/RAS cleared to RESET_VECTOR, `ras_err=0`. Reset mid-slot discards any pending redirect.
- Arithmetic is modulo 2^ADDR_WIDTH with silent wrap. `br_disp` is sign-extended.
- Redirect target computation:
  - Branch target = `pc + 1 + sext(br_disp)`.
  - Jump target = `jmp_addr`.
  - Return target = link (RAS top when RAS_EN).
- Priority when several requests occur in one cycle: `ret` > `jmp_req` > `br_req`.
- Two states, IDLE and PENDING, `pend=(state==PENDING)`:
  - IDLE, request with PCe=0: latch target, and call flag if jump. Go to PENDING.
  - IDLE, request with PCe=1: apply the live target to pc this edge. Stay IDLE.
  - IDLE, no request, PCe=1: `pc<=pc+1`.
  - PENDING, PCe=0, new request: new request overwrites the latched target (last request wins). Stay PENDING.
  - PENDING, PCe=1: `pc<=` live request target if any, else the latched target. Return to IDLE.
- `pc` changes only on a PCe=1 edge. Update latency is 1 clock after the PCe edge, and the new pc is visible the cycle after.
- Call: on the PCe edge applying a jump with call=1, save the return address as the pre-update `pc+1`.
- Without RAS_EN: a single link register holds the return address. `ret` targets link; link is unchanged by ret.
- `PCe` held high for consecutive cycles is legal; every such cycle advances the pc.

Optional Feature:
- Macro RAS_EN.
- Defined: return-address stack of RAS_DEPTH entries replaces the link register.
  - Call pushes `pc+1`. Ret pops the top, and the return target is the top read at latch time.
  - Push when full discards the oldest entry and sets `ras_err`.
  - Pop when empty targets RESET_VECTOR and sets `ras_err`.
  - `ras_err` is cleared only by reset.
  - Push and pop occur on the applying PCe edge, not at latch time.
- Undefined: single link register; `ras_err` tied 0.

Test Plan:
1. Reset, then PCe every 3rd cycle for 5 pulses -> pc sequence 0,1,2,3,4,5. pc is stable between pulses. pend stays 0.
2. pc=0x0010, br_req with br_disp=8'hFC, 2 cycles before PCe -> pend=1 until PCe; pc becomes 0x000D; pend returns to 0.
3. pc=0xFFFF, PCe with no request -> pc=0x0000 (wrap). pc=0x0002 with br_disp=8'h80 -> pc=0xFF83.
4. Same cycle br_req (disp 4), jmp_req (addr 0x0100) with PCe=0; then a jmp_req to 0x0200 before PCe -> pc=0x0200.
5. pc=0x0040, jmp_req+call to 0x0300, then ret -> pc=0x0300, then 0x0041. Reset asserted while pend=1 -> pc=RESET_VECTOR, pend=0 immediately.
6. With RAS_EN: 5 nested calls then 5 rets -> first 4 returns are correct (LIFO); 5th return goes to RESET_VECTOR; ras_err set at the 5th call and stays set.

Source files
------------

// File: rtl/program_counter.sv
// Program counter stage: advances on PCe and queues branch/jump/call/return redirects until the next PCe.
// Define RAS_EN to replace the single link register with a RAS_DEPTH-entry return-address stack.
module program_counter #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DISP_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'h0000,
    parameter int                    RAS_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PCe,
    input  logic                  br_req,
    input  logic [DISP_WIDTH-1:0] br_disp,
    input  logic                  jmp_req,
    input  logic [ADDR_WIDTH-1:0] jmp_addr,
    input  logic                  call,
    input  logic                  ret,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus1,
    output logic                  pend,
    output logic                  ras_err
);

    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
    logic                  call_q, call_d;
    logic                  ret_q, ret_d;

    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] br_tgt;
    logic [ADDR_WIDTH-1:0] ret_tgt;
    logic [ADDR_WIDTH-1:0] live_tgt;
    logic                  req;
    logic                  live_call;
    logic                  do_call;
    logic                  do_ret;

    assign pc_inc    = pc_q + ADDR_WIDTH'(1);
    assign br_tgt    = pc_inc + {{(ADDR_WIDTH-DISP_WIDTH){br_disp[DISP_WIDTH-1]}}, br_disp};
    assign req       = ret | jmp_req | br_req;
    assign live_call = ~ret & jmp_req & call;

    always_comb begin
        live_tgt = br_tgt;
        if (ret) begin
            live_tgt = ret_tgt;
        end else if (jmp_req) begin
            live_tgt = jmp_addr;
        end
    end

    // A live request on the PCe edge always beats whatever was latched earlier in the slot.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        call_d  = call_q;
        ret_d   = ret_q;
        do_call = 1'b0;
        do_ret  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !PCe) begin
                    tgt_d   = live_tgt;
                    call_d  = live_call;
                    ret_d   = ret;
                    state_d = PENDING;
                end else if (req && PCe) begin
                    pc_d    = live_tgt;
                    do_call = live_call;
                    do_ret  = ret;
                end else if (PCe) begin
                    pc_d = pc_inc;
                end
            end
            PENDING: begin
                if (PCe) begin
                    if (req) begin
                        pc_d    = live_tgt;
                        do_call = live_call;
                        do_ret  = ret;
                    end else begin
                        pc_d    = tgt_q;
                        do_call = call_q;
                        do_ret  = ret_q;
                    end
                    call_d  = 1'b0;
                    ret_d   = 1'b0;
                    state_d = IDLE;
                end else if (req) begin
                    tgt_d  = live_tgt;
                    call_d = live_call;
                    ret_d  = ret;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR;
            tgt_q   <= '0;
            call_q  <= 1'b0;
            ret_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            call_q  <= call_d;
            ret_q   <= ret_d;
        end
    end

`ifdef RAS_EN
    localparam int CW = $clog2(RAS_DEPTH + 1);

    // Entry 0 is the top; slots at or beyond the count always hold RESET_VECTOR, so an empty pop yields it.
    logic [ADDR_WIDTH-1:0] stack_q [RAS_DEPTH];
    logic [ADDR_WIDTH-1:0] stack_d [RAS_DEPTH];
    logic [CW-1:0]         count_q, count_d;
    logic                  err_q, err_d;

    assign ret_tgt = stack_q[0];
    assign ras_err = err_q;

    always_comb begin
        stack_d = stack_q;
        count_d = count_q;
        err_d   = err_q;
        if (do_call) begin
            for (int i = 1; i < RAS_DEPTH; i++) begin
                stack_d[i] = stack_q[i-1];
            end
            stack_d[0] = pc_inc;
            if (count_q == CW'(RAS_DEPTH)) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else if (do_ret) begin
            if (count_q == '0) begin
                err_d = 1'b1;
            end else begin
                for (int i = 0; i < RAS_DEPTH - 1; i++) begin
                    stack_d[i] = stack_q[i+1];
                end
                stack_d[RAS_DEPTH-1] = RESET_VECTOR;
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                stack_q[i] <= RESET_VECTOR;
            end
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stack_q <= stack_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end
`else
    logic [ADDR_WIDTH-1:0] link_q, link_d;
    logic                  unused_ras_depth;

    assign unused_ras_depth = (RAS_DEPTH > 0);
    assign ret_tgt          = link_q;
    assign ras_err          = 1'b0;

    always_comb begin
        link_d = link_q;
        if (do_call) begin
            link_d = pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_q <= RESET_VECTOR;
        end else begin
            link_q <= link_d;
        end
    end
`endif

    assign pc       = pc_q;
    assign pc_plus1 = pc_inc;
    assign pend     = (state_q == PENDING);

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: cycle vectors from a table plus hand-written call/return and reset sequences.
// Define RAS_EN to exercise the return-address stack instead of the link register.
module tb_program_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCe;
    logic        br_req;
    logic [7:0]  br_disp;
    logic        jmp_req;
    logic [15:0] jmp_addr;
    logic        call;
    logic        ret;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic        pend;
    logic        ras_err;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        string       name;
        logic        pce;
        logic        brReq;
        logic [7:0]  brDisp;
        logic        jmpReq;
        logic [15:0] jmpAddr;
        logic        callIn;
        logic        retIn;
        logic [15:0] expPc;
        logic        expPend;
    } vec_t;

    vec_t vecs[16];

    program_counter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .PCe      (PCe),
        .br_req   (br_req),
        .br_disp  (br_disp),
        .jmp_req  (jmp_req),
        .jmp_addr (jmp_addr),
        .call     (call),
        .ret      (ret),
        .pc       (pc),
        .pc_plus1 (pc_plus1),
        .pend     (pend),
        .ras_err  (ras_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(input string n, input logic pce, input logic br, input logic [7:0] d,
                                   input logic j, input logic [15:0] a, input logic c, input logic r,
                                   input logic [15:0] ep, input logic epd);
        vec_t v;
        v.name = n; v.pce = pce; v.brReq = br; v.brDisp = d; v.jmpReq = j; v.jmpAddr = a;
        v.callIn = c; v.retIn = r; v.expPc = ep; v.expPend = epd;
        return v;
    endfunction

    // Inputs are driven 1ns after a rising edge, held for exactly one cycle, then dropped.
    task automatic applyStimulus(input logic pce, input logic br, input logic [7:0] d, input logic j,
                                 input logic [15:0] a, input logic c, input logic r);
        PCe = pce; br_req = br; br_disp = d; jmp_req = j; jmp_addr = a; call = c; ret = r;
        @(posedge clk);
        #1;
        PCe = 1'b0; br_req = 1'b0; br_disp = 8'h00; jmp_req = 1'b0; jmp_addr = 16'h0000;
        call = 1'b0; ret = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic pulsePce();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic callTo(input logic [15:0] target);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, target, 1'b1, 1'b0);
    endtask

    task automatic retNow();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; PCe = 1'b0; br_req = 1'b0; br_disp = 8'h00; jmp_req = 1'b0;
        jmp_addr = 16'h0000; call = 1'b0; ret = 1'b0;

        vecs[0]  = mkVec("jmp_to_0010",   1, 0, 8'h00, 1, 16'h0010, 0, 0, 16'h0010, 0);
        vecs[1]  = mkVec("br_latch",      0, 1, 8'hFC, 0, 16'h0000, 0, 0, 16'h0010, 1);
        vecs[2]  = mkVec("br_wait",       0, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0010, 1);
        vecs[3]  = mkVec("br_back_apply", 1, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h000D, 0);
        vecs[4]  = mkVec("jmp_to_ffff",   1, 0, 8'h00, 1, 16'hFFFF, 0, 0, 16'hFFFF, 0);
        vecs[5]  = mkVec("pc_wrap",       1, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0000, 0);
        vecs[6]  = mkVec("inc_to_1",      1, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0001, 0);
        vecs[7]  = mkVec("inc_to_2",      1, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0002, 0);
        vecs[8]  = mkVec("br_neg_wrap",   1, 1, 8'h80, 0, 16'h0000, 0, 0, 16'hFF83, 0);
        vecs[9]  = mkVec("br_jmp_same",   0, 1, 8'h04, 1, 16'h0100, 0, 0, 16'hFF83, 1);
        vecs[10] = mkVec("jmp_overwrite", 0, 0, 8'h00, 1, 16'h0200, 0, 0, 16'hFF83, 1);
        vecs[11] = mkVec("last_wins",     1, 0, 8'h00, 0, 16'h0000, 0, 0, 16'h0200, 0);
        vecs[12] = mkVec("prio_jmp_br",   1, 1, 8'h04, 1, 16'h0100, 0, 0, 16'h0100, 0);
        vecs[13] = mkVec("prio_ret_jmp",  1, 0, 8'h00, 1, 16'h0500, 0, 1, 16'h0000, 0);
        vecs[14] = mkVec("br_latch2",     0, 1, 8'h02, 0, 16'h0000, 0, 0, 16'h0000, 1);
        vecs[15] = mkVec("pend_live_br",  1, 1, 8'h05, 0, 16'h0000, 0, 0, 16'h0006, 0);

        doReset();
        checkOutput("reset_pc", pc, 16'h0000);
        checkOutput("reset_pend", {15'b0, pend}, 16'h0000);
        checkOutput("reset_ras_err", {15'b0, ras_err}, 16'h0000);

        // Five PCe pulses, one per three-cycle slot; pc must hold between pulses.
        for (int k = 1; k <= 5; k++) begin
            idleCycle();
            checkOutput($sformatf("hold_a_%0d", k), pc, 16'(k - 1));
            idleCycle();
            checkOutput($sformatf("hold_b_%0d", k), pc, 16'(k - 1));
            pulsePce();
            checkOutput($sformatf("seq_pc_%0d", k), pc, 16'(k));
            checkOutput($sformatf("seq_pend_%0d", k), {15'b0, pend}, 16'h0000);
        end
        checkOutput("pc_plus1", pc_plus1, 16'h0006);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].pce, vecs[i].brReq, vecs[i].brDisp, vecs[i].jmpReq,
                          vecs[i].jmpAddr, vecs[i].callIn, vecs[i].retIn);
            checkOutput({vecs[i].name, "_pc"}, pc, vecs[i].expPc);
            checkOutput({vecs[i].name, "_pend"}, {15'b0, pend}, {15'b0, vecs[i].expPend});
        end

        // Latched call, latched return to the saved pc+1.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 16'h0040, 1'b0, 1'b0);
        checkOutput("jmp_to_0040", pc, 16'h0040);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 16'h0300, 1'b1, 1'b0);
        checkOutput("call_latched", {15'b0, pend}, 16'h0001);
        idleCycle();
        pulsePce();
        checkOutput("call_applied", pc, 16'h0300);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("ret_latched_pc", pc, 16'h0300);
        checkOutput("ret_latched_pend", {15'b0, pend}, 16'h0001);
        pulsePce();
        checkOutput("ret_applied", pc, 16'h0041);
`ifndef RAS_EN
        retNow();
        checkOutput("link_kept", pc, 16'h0041);
        checkOutput("ras_err_tied", {15'b0, ras_err}, 16'h0000);
`endif

        // Asynchronous reset mid-slot wipes the pending redirect without a clock edge.
        applyStimulus(1'b0, 1'b1, 8'h10, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("pre_reset_pend", {15'b0, pend}, 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_pc", pc, 16'h0000);
        checkOutput("async_reset_pend", {15'b0, pend}, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulsePce();
        checkOutput("redirect_discarded", pc, 16'h0001);

`ifdef RAS_EN
        doReset();
        callTo(16'h1000);
        callTo(16'h2000);
        callTo(16'h3000);
        callTo(16'h4000);
        checkOutput("ras_err_after_4", {15'b0, ras_err}, 16'h0000);
        callTo(16'h5000);
        checkOutput("call5_pc", pc, 16'h5000);
        checkOutput("ras_err_after_5", {15'b0, ras_err}, 16'h0001);
        retNow();
        checkOutput("ret1", pc, 16'h4001);
        retNow();
        checkOutput("ret2", pc, 16'h3001);
        retNow();
        checkOutput("ret3", pc, 16'h2001);
        retNow();
        checkOutput("ret4", pc, 16'h1001);
        retNow();
        checkOutput("ret5_underflow", pc, 16'h0000);
        checkOutput("ras_err_sticky", {15'b0, ras_err}, 16'h0001);
        pulsePce();
        checkOutput("ras_err_still", {15'b0, ras_err}, 16'h0001);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
